if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter DSize, default 32: width of the instruction and PC datapaths.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  fetch presents a valid instruction.
REQ-005 in_ready  output  1  stage can accept a transfer this cycle.
REQ-006 in_instr  input  DSize  fetched instruction word.
REQ-007 in_pc  input  DSize  PC of in_instr.
REQ-008 flush  input  1  synchronous kill of all held instructions.
REQ-009 out_valid  output  1  head entry valid toward the execute stage.
REQ-010 out_ready  input  1  downstream accepts the head entry.
REQ-011 out_instr, out_pc  output  DSize each  head entry instruction and PC.
REQ-012 imm_field  output  20  out_instr[19:0], the field driven to the immediate extension unit.
REQ-013 ext_s1, ext_s0  output  1 each  extension select; {ext_s1,ext_s0}: 00 imm5 ZE [14:10], 01 imm15 SE, 10 imm15 ZE, 11 imm20 SE.
REQ-014 imm_en  output  1  head instruction uses an extended immediate.

Function
REQ-015 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready; entries leave in arrival order.
REQ-016 Decode SHALL be computed from in_instr at capture and stored with the entry; outputs SHALL be registered, no combinational path from in_instr to any output.
REQ-017 opcode = instr[30:25]; instr[31]=1 SHALL give imm_en=0, select 00.
REQ-018 opcode 0x20 with instr[4:0] in {0x08,0x09,0x0A,0x0B}: imm_en=1, select 00.
REQ-019 opcode in {0x28,0x29,0x2E,0x2F}: imm_en=1, select 01.
REQ-020 opcode in {0x2A,0x2B,0x2C}: imm_en=1, select 10.
REQ-021 opcode 0x22: imm_en=1, select 11.
REQ-022 Any other opcode: imm_en=0, select 00.
REQ-023 Latency: an instruction captured in cycle N SHALL be visible at outputs in cycle N+1 if the stage was empty or the head left in cycle N.
REQ-024 Simultaneous in and out transfer with one entry held SHALL keep occupancy at one, new entry becomes head.
REQ-025 Full: in_ready=0; a held in_valid SHALL not be lost or duplicated.
REQ-026 Empty: out_valid=0; out_instr/out_pc hold their last value; imm_en and select SHALL be 0.
REQ-027 flush SHALL override all transfers: next cycle occupancy 0, out_valid=0; an input presented in the flush cycle SHALL be discarded.
REQ-028 Downstream stalled (out_ready=0): outputs SHALL remain stable until accepted.

Reset
REQ-029 While rst_n=0: occupancy 0, out_valid=0, out_instr=0, out_pc=0, imm_field=0, ext_s0=ext_s1=0, imm_en=0.
REQ-030 in_ready SHALL be 0 during reset and 1 the first cycle after release.
REQ-031 Reset asserted mid-transfer SHALL discard all entries without partial update.

Configuration
REQ-032 Macro ID_SKID_EN defined: two-entry skid buffer; in_ready SHALL be a registered signal (=1 when occupancy<2), with no path from out_ready.
REQ-033 ID_SKID_EN undefined: single entry; in_ready = !out_valid || out_ready (combinational); all other requirements unchanged.

Verification
REQ-034 Reset release, in_instr=0x50007FFF (ADDI) valid, out_ready=1 -> next cycle out_valid=1, imm_field=0x07FFF, select 01, imm_en=1.
REQ-035 in_instr=0x44080000 (MOVI) -> imm_field=0x80000, select 11; 0x58001234 (ORI) -> select 10; 0x40000C08 (SLLI, imm5=3) -> select 00, imm_en=1.
REQ-036 ID_SKID_EN: out_ready=0, three back-to-back inputs PC 0x0,0x4,0x8 -> in_ready low after two accepted, 0x8 held by fetch; out_ready=1 -> outputs 0x0,0x4,0x8 in order, no gaps or duplicates.
REQ-037 Two entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-038 rst_n low for one cycle while full -> outputs at REQ-029 values immediately, empty after release.
REQ-039 Random in_valid/out_ready for 10k cycles, both configurations -> output stream equals input stream order; decode matches REQ-017..022 reference model.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: holds fetched instructions with their pre-decoded immediate select.
// Define ID_SKID_EN for a two-entry skid buffer with registered in_ready; default is a single entry.
module if_id_stage #(
  parameter int unsigned DSize = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSize-1:0] in_instr,
  input  logic [DSize-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSize-1:0] out_instr,
  output logic [DSize-1:0] out_pc,
  output logic [19:0]      imm_field,
  output logic             ext_s1,
  output logic             ext_s0,
  output logic             imm_en
);

  typedef struct packed {
    logic [DSize-1:0] instr;
    logic [DSize-1:0] pc;
    logic             imm_en;
    logic [1:0]       sel;
  } entry_t;

  // hi = instr[31:25], lo = instr[4:0]; result = {imm_en, ext_s1, ext_s0}
  function automatic logic [2:0] decode(input logic [6:0] hi, input logic [4:0] lo);
    logic [2:0] d;
    d = '0;
    if (!hi[6]) begin
      case (hi[5:0])
        6'h20:                      if (lo inside {5'h08, 5'h09, 5'h0A, 5'h0B}) d = 3'b100;
        6'h28, 6'h29, 6'h2E, 6'h2F: d = 3'b101;
        6'h2A, 6'h2B, 6'h2C:        d = 3'b110;
        6'h22:                      d = 3'b111;
        default:                    d = 3'b000;
      endcase
    end
    return d;
  endfunction

  logic [2:0] in_dec;
  entry_t     in_e;
  entry_t     head_q, head_d;
  logic       hv_q, hv_d;
  logic       push, pop;

  always_comb begin
    in_dec       = decode(in_instr[31:25], in_instr[4:0]);
    in_e.instr   = in_instr;
    in_e.pc      = in_pc;
    in_e.imm_en  = in_dec[2];
    in_e.sel     = in_dec[1:0];
  end

  assign push = in_valid & in_ready;
  assign pop  = hv_q & out_ready;

  assign out_valid          = hv_q;
  assign out_instr          = head_q.instr;
  assign out_pc             = head_q.pc;
  assign imm_field          = head_q.instr[19:0];
  assign {ext_s1, ext_s0}   = head_q.sel;
  assign imm_en             = head_q.imm_en;

`ifdef ID_SKID_EN
  entry_t sk_q, sk_d;
  logic   skv_q, skv_d;
  logic   rdy_q, rdy_d;

  assign in_ready = rdy_q;

  always_comb begin
    head_d = head_q;
    hv_d   = hv_q;
    sk_d   = sk_q;
    skv_d  = skv_q;
    if (flush) begin
      hv_d          = 1'b0;
      skv_d         = 1'b0;
      head_d.imm_en = 1'b0;
      head_d.sel    = '0;
    end else if (!hv_q || pop) begin
      // Head slot frees up: the skid entry is older than anything arriving now.
      if (skv_q) begin
        head_d = sk_q;
        hv_d   = 1'b1;
        skv_d  = push;
        if (push) sk_d = in_e;
      end else if (push) begin
        head_d = in_e;
        hv_d   = 1'b1;
      end else begin
        hv_d          = 1'b0;
        head_d.imm_en = 1'b0;
        head_d.sel    = '0;
      end
    end else if (push) begin
      sk_d  = in_e;
      skv_d = 1'b1;
    end
    rdy_d = !skv_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      hv_q   <= 1'b0;
      sk_q   <= '0;
      skv_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      hv_q   <= hv_d;
      sk_q   <= sk_d;
      skv_q  <= skv_d;
      rdy_q  <= rdy_d;
    end
  end
`else
  logic alive_q;

  // alive_q keeps in_ready low until the first edge after reset release.
  assign in_ready = alive_q & (!hv_q | out_ready);

  always_comb begin
    head_d = head_q;
    hv_d   = hv_q;
    if (flush) begin
      hv_d          = 1'b0;
      head_d.imm_en = 1'b0;
      head_d.sel    = '0;
    end else if (push) begin
      head_d = in_e;
      hv_d   = 1'b1;
    end else if (pop) begin
      hv_d          = 1'b0;
      head_d.imm_en = 1'b0;
      head_d.sel    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      hv_q    <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      hv_q    <= hv_d;
      alive_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: directed decode, stall, flush and reset steps, then random traffic.
module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [19:0] imm_field;
  logic        ext_s1;
  logic        ext_s0;
  logic        imm_en;

  if_id_stage #(.DSize(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .imm_field (imm_field),
    .ext_s1    (ext_s1),
    .ext_s0    (ext_s0),
    .imm_en    (imm_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  dec;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed;
  int unsigned total;
  int unsigned dut_pops;
  logic        alive;
  logic        accepted;
  logic [31:0] last_instr;
  logic [31:0] last_pc;
  int unsigned stall;

  // Reference decode: {imm_en, ext_s1, ext_s0}
  function automatic logic [2:0] ref_dec(input logic [31:0] w);
    logic [5:0] op;
    op = w[30:25];
    if (w[31]) return 3'b000;
    if (op == 6'h22) return 3'b111;
    if (op == 6'h2A || op == 6'h2B || op == 6'h2C) return 3'b110;
    if (op == 6'h28 || op == 6'h29 || op == 6'h2E || op == 6'h2F) return 3'b101;
    if (op == 6'h20 && w[4:0] >= 5'h08 && w[4:0] <= 5'h0B) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0]  ops [12];
    logic [31:0] w;
    ops = '{6'h20, 6'h22, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2E, 6'h2F, 6'h21, 6'h2D, 6'h00};
    w = $urandom;
    if (($urandom % 4) != 0) w[30:25] = ops[$urandom % 12];
    if (($urandom % 2) != 0) w[4:0] = 5'(5'h08 + ($urandom % 5));
    w[31] = (($urandom % 8) == 0);
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_instr"}, 64'(out_instr), 64'(0));
    check({tag, "_out_pc"},    64'(out_pc),    64'(0));
    check({tag, "_imm_field"}, 64'(imm_field), 64'(0));
    check({tag, "_ext_sel"},   64'({ext_s1, ext_s0}), 64'(0));
    check({tag, "_imm_en"},    64'(imm_en),    64'(0));
    check({tag, "_in_ready"},  64'(in_ready),  64'(0));
  endtask

  task automatic monitor();
    logic exp_v;
    logic exp_r;
    exp_v = (sb.size() != 0);
`ifdef ID_SKID_EN
    exp_r = alive && (sb.size() < 2);
`else
    exp_r = alive && (!exp_v || out_ready);
`endif
    check("out_valid", 64'(out_valid), 64'(exp_v));
    check("in_ready",  64'(in_ready),  64'(exp_r));
    if (exp_v) begin
      last_instr = sb[0].instr;
      last_pc    = sb[0].pc;
      check("out_instr", 64'(out_instr), 64'(sb[0].instr));
      check("out_pc",    64'(out_pc),    64'(sb[0].pc));
      check("imm_field", 64'(imm_field), 64'(sb[0].instr[19:0]));
      check("ext_sel",   64'({ext_s1, ext_s0}), 64'(sb[0].dec[1:0]));
      check("imm_en",    64'(imm_en),    64'(sb[0].dec[2]));
    end else begin
      check("empty_imm_en",  64'(imm_en),  64'(0));
      check("empty_ext_sel", 64'({ext_s1, ext_s0}), 64'(0));
      check("hold_instr",    64'(out_instr), 64'(last_instr));
      check("hold_pc",       64'(out_pc),    64'(last_pc));
    end
    if (out_valid && out_ready && !flush) dut_pops = dut_pops + 1;
    accepted = 1'b0;
    if (flush) begin
      sb.delete();
    end else begin
      if (exp_v && out_ready) void'(sb.pop_front());
      if (in_valid && exp_r) begin
        sb.push_back('{in_instr, in_pc, ref_dec(in_instr)});
        accepted = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    if (rst_n) alive = 1'b1;
    #1;
  endtask

  task automatic send_dir(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [19:0] e_imm, input logic [1:0] e_sel, input logic e_en);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_imm"},   64'(imm_field), 64'(e_imm));
    check({tag, "_sel"},   64'({ext_s1, ext_s0}), 64'(e_sel));
    check({tag, "_en"},    64'(imm_en),    64'(e_en));
    step();
  endtask

  initial begin
    passed = 0; total = 0; dut_pops = 0;
    alive = 1'b0; accepted = 1'b0;
    last_instr = '0; last_pc = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_instr = '0; in_pc = '0;

    #3;
    check_reset("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    send_dir("addi", 32'h5000_7FFF, 32'h0000_0100, 20'h07FFF, 2'b01, 1'b1);
    send_dir("movi", 32'h4408_0000, 32'h0000_0104, 20'h80000, 2'b11, 1'b1);
    send_dir("ori",  32'h5800_1234, 32'h0000_0108, 20'h01234, 2'b10, 1'b1);
    send_dir("slli", 32'h4000_0C08, 32'h0000_010C, 20'h00C08, 2'b00, 1'b1);
    send_dir("b31",  32'hC408_0000, 32'h0000_0110, 20'h80000, 2'b00, 1'b0);
    send_dir("op20", 32'h4000_000C, 32'h0000_0114, 20'h0000C, 2'b00, 1'b0);

    // Back-to-back PCs 0x0/0x4/0x8 against a stalled consumer, each held until taken.
    out_ready = 1'b0;
    stall     = 0;
    dut_pops  = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h5000_0000 | 32'(k);
      in_pc    = 32'(k * 4);
      for (int t = 0; t < 20; t++) begin
        step();
        if (accepted) break;
        stall = stall + 1;
        if (stall >= 3) out_ready = 1'b1;
      end
      check("b2b_accept", 64'(accepted), 64'(1));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("b2b_count", 64'(dut_pops), 64'(3));

    // Fill, then flush with a live input that must never surface.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = rand_instr();
      in_pc    = 32'h200 + 32'(k * 4);
      step();
    end
    flush    = 1'b1;
    in_instr = 32'hDEAD_BEEF;
    in_pc    = 32'h0BAD_0000;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ready", 64'(in_ready),  64'(1));
    out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset while full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_instr = rand_instr();
      in_pc    = 32'h300 + 32'(k * 4);
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset("midrst");
    sb.delete();
    alive = 1'b0; last_instr = '0; last_pc = '0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    check("postrst_valid", 64'(out_valid), 64'(0));
    check("postrst_ready", 64'(in_ready),  64'(1));

    for (int i = 0; i < 10000; i++) begin
      in_valid  = (($urandom % 4) != 0);
      out_ready = (($urandom % 3) != 0);
      flush     = (($urandom % 64) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("drain_empty", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
